pc_seq: RTL and testbench

PC_SEQ -- requirements
Module: pc_seq

---
 rtl/pc_seq.sv | 179 +++++++++++++++++
 tb/tb_pc_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq.sv
// pc_seq -- program counter sequencer with vectored interrupt entry.
//
// Chooses the next PC among sequential, branch, jump, register-jump and
// illegal-op targets, captures rising edges of the interrupt request lines
// into a pending register and, in user mode, diverts the PC to a per-line
// interrupt vector while saving the abandoned PC in epc.
//
// Build option: define PC_SEQ_IRQ_MASK_EN to get a writable interrupt mask
// register. Without it the mask is fixed at all ones and mask_we/mask_wdata
// are ignored.
module pc_seq #(
  parameter int          NIRQ       = 4,
  parameter logic [31:0] RESET_VEC  = 32'h80000000,
  parameter logic [31:0] ILLOP_VEC  = 32'h80000004,
  parameter logic [31:0] XADR_VEC   = 32'h80000008,
  parameter logic [31:0] VEC_STRIDE = 32'd0
) (
  input  logic            sysclk,
  input  logic            reset,
  input  logic            stall,
  input  logic [2:0]      pc_src,
  input  logic            br_taken,
  input  logic [31:0]     br_off,
  input  logic [25:0]     jidx,
  input  logic [31:0]     jr_tgt,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_wdata,
  output logic [31:0]     pc,
  output logic [31:0]     pc_plus4,
  output logic [31:0]     epc,
  output logic            kernel,
  output logic            irq_take,
  output logic [3:0]      irq_cause,
  output logic [NIRQ-1:0] pending
);

  localparam logic [2:0] SRC_SEQ    = 3'd0;
  localparam logic [2:0] SRC_BRANCH = 3'd1;
  localparam logic [2:0] SRC_JUMP   = 3'd2;
  localparam logic [2:0] SRC_JR     = 3'd3;

  logic [31:0]     pc_reg;
  logic [31:0]     pc_next;
  logic [31:0]     epc_reg;
  logic [31:0]     epc_next;
  logic [NIRQ-1:0] pending_reg;
  logic [NIRQ-1:0] pending_next;
  logic [NIRQ-1:0] irq_hist_reg;
  logic [NIRQ-1:0] irq_rise;
  logic [NIRQ-1:0] mask_val;
  logic [NIRQ-1:0] eligible;
  logic [NIRQ-1:0] clr_onehot;
  logic [3:0]      cause_sel;
  logic            any_eligible;
  logic            take;
  logic [31:0]     seq_pc;
  logic [31:0]     branch_pc;
  logic [31:0]     jump_pc;
  logic [31:0]     jr_pc;
  logic [31:0]     irq_vec;

  // ---------------------------------------------------------------------
  // Interrupt mask: writable register or constant all ones
  // ---------------------------------------------------------------------
`ifdef PC_SEQ_IRQ_MASK_EN
  logic [NIRQ-1:0] mask_reg;

  // Mask register; writes are honoured even while the pipeline is stalled.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      mask_reg <= '1;
    end else if (mask_we) begin
      mask_reg <= mask_wdata;
    end
  end

  assign mask_val = mask_reg;
`else
  logic unused_mask_inputs;

  assign mask_val           = '1;
  assign unused_mask_inputs = ^{mask_we, mask_wdata};
`endif

  // ---------------------------------------------------------------------
  // Edge detection, eligibility and pending-bit update, one slice per line
  // ---------------------------------------------------------------------
  assign irq_rise = irq_in & ~irq_hist_reg;

  generate
    for (genvar gi = 0; gi < NIRQ; gi++) begin : g_line
      assign eligible[gi]     = pending_reg[gi] & mask_val[gi];
      assign clr_onehot[gi]   = take && (cause_sel == 4'(gi));
      // A fresh edge wins over the clear so a request arriving while its
      // previous instance is being serviced is not lost.
      assign pending_next[gi] = irq_rise[gi] | (pending_reg[gi] & ~clr_onehot[gi]);
    end
  endgenerate

  assign any_eligible = |eligible;

  // Lowest-index eligible line wins: scan downwards so the last hit is the lowest.
  always_comb begin
    cause_sel = 4'd0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        cause_sel = 4'(i);
      end
    end
  end

  // Interrupts are only entered from user mode on an unstalled cycle.
  assign take      = any_eligible & ~pc_reg[31] & ~stall;
  assign irq_take  = take;
  assign irq_cause = take ? cause_sel : 4'd0;

  // ---------------------------------------------------------------------
  // Candidate targets (all arithmetic wraps modulo 2^32)
  // ---------------------------------------------------------------------
  assign seq_pc    = pc_reg + 32'd4;
  assign branch_pc = seq_pc + {br_off[29:0], 2'b00};
  assign jump_pc   = {seq_pc[31:28], jidx, 2'b00};
  // User code cannot reach kernel space through a register jump.
  assign jr_pc     = pc_reg[31] ? jr_tgt : {1'b0, jr_tgt[30:0]};
  assign irq_vec   = XADR_VEC + ({28'd0, cause_sel} * VEC_STRIDE);

  // Next PC / EPC selection; interrupt entry overrides every pc_src value.
  always_comb begin
    pc_next  = pc_reg;
    epc_next = epc_reg;
    if (!stall) begin
      if (take) begin
        pc_next  = irq_vec;
        epc_next = pc_reg;
      end else begin
        case (pc_src)
          SRC_SEQ:    pc_next = seq_pc;
          SRC_BRANCH: pc_next = br_taken ? branch_pc : seq_pc;
          SRC_JUMP:   pc_next = jump_pc;
          SRC_JR:     pc_next = jr_pc;
          default: begin
            pc_next  = ILLOP_VEC;
            epc_next = seq_pc;
          end
        endcase
      end
    end
  end

  // PC and EPC registers; the stall hold is folded into pc_next/epc_next.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      pc_reg  <= RESET_VEC;
      epc_reg <= 32'd0;
    end else begin
      pc_reg  <= pc_next;
      epc_reg <= epc_next;
    end
  end

  // Request history and pending capture keep running during stall and kernel mode.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      irq_hist_reg <= '0;
      pending_reg  <= '0;
    end else begin
      irq_hist_reg <= irq_in;
      pending_reg  <= pending_next;
    end
  end

  assign pc       = pc_reg;
  assign pc_plus4 = seq_pc;
  assign epc      = epc_reg;
  assign kernel   = pc_reg[31];
  assign pending  = pending_reg;

endmodule

// File: tb/tb_pc_seq.sv
// Directed testbench for pc_seq (NIRQ=4, VEC_STRIDE=16).
module tb_pc_seq;

  localparam int NIRQ = 4;

  logic            sysclk;
  logic            reset;
  logic            stall;
  logic [2:0]      pc_src;
  logic            br_taken;
  logic [31:0]     br_off;
  logic [25:0]     jidx;
  logic [31:0]     jr_tgt;
  logic [NIRQ-1:0] irq_in;
  logic            mask_we;
  logic [NIRQ-1:0] mask_wdata;
  logic [31:0]     pc;
  logic [31:0]     pc_plus4;
  logic [31:0]     epc;
  logic            kernel;
  logic            irq_take;
  logic [3:0]      irq_cause;
  logic [NIRQ-1:0] pending;

  int tests_run = 0;
  int tests_failed = 0;

  pc_seq #(
    .NIRQ(NIRQ),
    .RESET_VEC(32'h80000000),
    .ILLOP_VEC(32'h80000004),
    .XADR_VEC(32'h80000008),
    .VEC_STRIDE(32'd16)
  ) dut (
    .sysclk(sysclk), .reset(reset), .stall(stall), .pc_src(pc_src),
    .br_taken(br_taken), .br_off(br_off), .jidx(jidx), .jr_tgt(jr_tgt),
    .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .kernel(kernel),
    .irq_take(irq_take), .irq_cause(irq_cause), .pending(pending)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    tests_run++; if (pc !== 32'h80000000) begin tests_failed++; $display("FAIL reset_pc: got %h want %h", pc, 32'h80000000); end
    tests_run++; if (epc !== 32'h0) begin tests_failed++; $display("FAIL reset_epc: got %h want 0", epc); end
    tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL reset_pending: got %b want 0000", pending); end
    tests_run++; if (kernel !== 1'b1 || irq_take !== 1'b0 || irq_cause !== 4'd0) begin tests_failed++; $display("FAIL reset_flags: kernel=%b irq_take=%b cause=%0d want 1/0/0", kernel, irq_take, irq_cause); end
    $display("[TB] reset: pc=%h epc=%h pending=%b", pc, epc, pending);
  endtask

  task automatic test_seq();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h80000000; exp_pc[1] = 32'h80000004;
    exp_pc[2] = 32'h80000008; exp_pc[3] = 32'h8000000C;
    reset = 1'b0;
    pc_src = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      tests_run++; if (pc !== exp_pc[i]) begin tests_failed++; $display("FAIL seq%0d: pc=%h want %h", i, pc, exp_pc[i]); end
      $display("[TB] seq %0d: pc=%h", i, pc);
    end
  endtask

  task automatic test_branch_jump();
    pc_src = 3'd3; jr_tgt = 32'h00400010; step();
    tests_run++; if (pc !== 32'h00400010 || kernel !== 1'b0) begin tests_failed++; $display("FAIL setup_user: pc=%h kernel=%b want 00400010/0", pc, kernel); end
    pc_src = 3'd1; br_taken = 1'b1; br_off = 32'hFFFFFFFE; step();
    tests_run++; if (pc !== 32'h0040000C) begin tests_failed++; $display("FAIL branch_taken: pc=%h want 0040000c", pc); end
    $display("[TB] branch taken: pc=%h", pc);
    br_taken = 1'b0; step();
    tests_run++; if (pc !== 32'h00400010) begin tests_failed++; $display("FAIL branch_not_taken: pc=%h want 00400010", pc); end
    $display("[TB] branch not taken: pc=%h", pc);
    pc_src = 3'd2; jidx = 26'h3FFFFFF; step();
    tests_run++; if (pc !== 32'h0FFFFFFC) begin tests_failed++; $display("FAIL jump: pc=%h want 0ffffffc", pc); end
    $display("[TB] jump: pc=%h", pc);
  endtask

  task automatic test_jr();
    pc_src = 3'd3; jr_tgt = 32'h00400020; step();
    tests_run++; if (pc !== 32'h00400020) begin tests_failed++; $display("FAIL jr_user_plain: pc=%h want 00400020", pc); end
    jr_tgt = 32'h80001000; step();
    tests_run++; if (pc !== 32'h00001000) begin tests_failed++; $display("FAIL jr_user_clip: pc=%h want 00001000", pc); end
    $display("[TB] jr user: pc=%h", pc);
    pc_src = 3'd4; step();
    tests_run++; if (pc !== 32'h80000004 || epc !== 32'h00001004) begin tests_failed++; $display("FAIL illop: pc=%h epc=%h want 80000004/00001004", pc, epc); end
    $display("[TB] illop: pc=%h epc=%h", pc, epc);
    pc_src = 3'd3; jr_tgt = 32'h80001000; step();
    tests_run++; if (pc !== 32'h80001000) begin tests_failed++; $display("FAIL jr_kernel: pc=%h want 80001000", pc); end
    $display("[TB] jr kernel: pc=%h", pc);
  endtask

  task automatic test_wrap();
    pc_src = 3'd3; jr_tgt = 32'hFFFFFFFC; step();
    tests_run++; if (pc !== 32'hFFFFFFFC || pc_plus4 !== 32'h0) begin tests_failed++; $display("FAIL wrap_plus4: pc=%h pc_plus4=%h want fffffffc/00000000", pc, pc_plus4); end
    pc_src = 3'd0; step();
    tests_run++; if (pc !== 32'h0) begin tests_failed++; $display("FAIL wrap_seq: pc=%h want 0", pc); end
    $display("[TB] wrap: pc=%h", pc);
    pc_src = 3'd7; step();
    tests_run++; if (pc !== 32'h80000004 || epc !== 32'h00000004) begin tests_failed++; $display("FAIL src7_illop: pc=%h epc=%h want 80000004/00000004", pc, epc); end
    $display("[TB] pc_src=7: pc=%h epc=%h", pc, epc);
  endtask

  task automatic test_irq_priority();
    pc_src = 3'd3; jr_tgt = 32'h00400100; irq_in = 4'b1010; step();
    tests_run++; if (pending !== 4'b1010 || irq_take !== 1'b1 || irq_cause !== 4'd1) begin tests_failed++; $display("FAIL irq_prio: pending=%b take=%b cause=%0d want 1010/1/1", pending, irq_take, irq_cause); end
    pc_src = 3'd0; step();
    tests_run++; if (pc !== 32'h80000018 || epc !== 32'h00400100 || pending !== 4'b1000) begin tests_failed++; $display("FAIL irq_entry1: pc=%h epc=%h pending=%b want 80000018/00400100/1000", pc, epc, pending); end
    tests_run++; if (irq_take !== 1'b0 || irq_cause !== 4'd0) begin tests_failed++; $display("FAIL irq_kernel_block: take=%b cause=%0d want 0/0", irq_take, irq_cause); end
    $display("[TB] irq line1: pc=%h epc=%h pending=%b", pc, epc, pending);
    irq_in = 4'b1000; pc_src = 3'd3; jr_tgt = 32'h00400100; step();
    tests_run++; if (irq_take !== 1'b1 || irq_cause !== 4'd3) begin tests_failed++; $display("FAIL irq_line3_take: take=%b cause=%0d want 1/3", irq_take, irq_cause); end
    pc_src = 3'd0; step();
    tests_run++; if (pc !== 32'h80000038 || pending !== 4'b0000) begin tests_failed++; $display("FAIL irq_entry3: pc=%h pending=%b want 80000038/0000", pc, pending); end
    $display("[TB] irq line3: pc=%h pending=%b", pc, pending);
    step();
    tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL level_no_reset: pending=%b want 0000", pending); end
  endtask

  task automatic test_illop_vs_irq();
    pc_src = 3'd3; jr_tgt = 32'h00400200; irq_in = 4'b0000; step();
    irq_in = 4'b0001; pc_src = 3'd0; step();
    tests_run++; if (pc !== 32'h00400204 || pending !== 4'b0001) begin tests_failed++; $display("FAIL illop_setup: pc=%h pending=%b want 00400204/0001", pc, pending); end
    pc_src = 3'd4;
    tests_run++; if (irq_take !== 1'b1 || irq_cause !== 4'd0) begin tests_failed++; $display("FAIL illop_irq_take: take=%b cause=%0d want 1/0", irq_take, irq_cause); end
    step();
    tests_run++; if (pc !== 32'h80000008 || epc !== 32'h00400204) begin tests_failed++; $display("FAIL illop_irq_win: pc=%h epc=%h want 80000008/00400204", pc, epc); end
    $display("[TB] illop+irq: pc=%h epc=%h", pc, epc);
  endtask

  task automatic test_stall();
    pc_src = 3'd3; jr_tgt = 32'h00400300; step();
    irq_in = 4'b0010; stall = 1'b1; pc_src = 3'd0; step();
    tests_run++; if (pc !== 32'h00400300 || pending !== 4'b0010 || irq_take !== 1'b0) begin tests_failed++; $display("FAIL stall_hold: pc=%h pending=%b take=%b want 00400300/0010/0", pc, pending, irq_take); end
    step();
    tests_run++; if (pc !== 32'h00400300 || epc !== 32'h00400204) begin tests_failed++; $display("FAIL stall_hold2: pc=%h epc=%h want 00400300/00400204", pc, epc); end
    stall = 1'b0; #1;
    tests_run++; if (irq_take !== 1'b1 || irq_cause !== 4'd1) begin tests_failed++; $display("FAIL stall_release_take: take=%b cause=%0d want 1/1", irq_take, irq_cause); end
    step();
    tests_run++; if (pc !== 32'h80000018 || epc !== 32'h00400300) begin tests_failed++; $display("FAIL stall_entry: pc=%h epc=%h want 80000018/00400300", pc, epc); end
    $display("[TB] stall then irq: pc=%h epc=%h", pc, epc);
  endtask

  task automatic test_clear_collision();
    pc_src = 3'd3; jr_tgt = 32'h00400400; irq_in = 4'b0000; step();
    stall = 1'b1; pc_src = 3'd0; irq_in = 4'b0100; step();
    irq_in = 4'b0000; step();
    stall = 1'b0; irq_in = 4'b0100; #1;
    tests_run++; if (irq_take !== 1'b1 || irq_cause !== 4'd2) begin tests_failed++; $display("FAIL collide_take: take=%b cause=%0d want 1/2", irq_take, irq_cause); end
    step();
    tests_run++; if (pc !== 32'h80000028 || pending !== 4'b0100) begin tests_failed++; $display("FAIL collide_keep: pc=%h pending=%b want 80000028/0100", pc, pending); end
    $display("[TB] clear+edge: pc=%h pending=%b", pc, pending);
    pc_src = 3'd3; jr_tgt = 32'h00400500; step();
    pc_src = 3'd0; step();
    tests_run++; if (pc !== 32'h80000028 || pending !== 4'b0000) begin tests_failed++; $display("FAIL collide_drain: pc=%h pending=%b want 80000028/0000", pc, pending); end
  endtask

  task automatic test_mask();
    pc_src = 3'd3; jr_tgt = 32'h00400600; irq_in = 4'b0000;
    mask_we = 1'b1; mask_wdata = 4'b1101; step();
    mask_we = 1'b0; pc_src = 3'd0; irq_in = 4'b0010; step();
`ifdef PC_SEQ_IRQ_MASK_EN
    tests_run++; if (irq_take !== 1'b0 || pending !== 4'b0010 || pc !== 32'h00400604) begin tests_failed++; $display("FAIL mask_block: take=%b pending=%b pc=%h want 0/0010/00400604", irq_take, pending, pc); end
    mask_we = 1'b1; mask_wdata = 4'hF; step();
    mask_we = 1'b0;
    tests_run++; if (irq_take !== 1'b1 || irq_cause !== 4'd1 || pc !== 32'h00400608) begin tests_failed++; $display("FAIL mask_open: take=%b cause=%0d pc=%h want 1/1/00400608", irq_take, irq_cause, pc); end
    step();
`else
    tests_run++; if (irq_take !== 1'b1 || irq_cause !== 4'd1) begin tests_failed++; $display("FAIL mask_ignored: take=%b cause=%0d want 1/1", irq_take, irq_cause); end
    mask_we = 1'b1; mask_wdata = 4'hF; step();
    mask_we = 1'b0;
`endif
    tests_run++; if (pc !== 32'h80000018 || pending !== 4'b0000) begin tests_failed++; $display("FAIL mask_entry: pc=%h pending=%b want 80000018/0000", pc, pending); end
    $display("[TB] mask: pc=%h epc=%h pending=%b", pc, epc, pending);
  endtask

  task automatic test_reset_mid();
    irq_in = 4'b0011; step();
    tests_run++; if (pending !== 4'b0001) begin tests_failed++; $display("FAIL pre_reset_pending: pending=%b want 0001", pending); end
    pc_src = 3'd2; jidx = 26'h0001234;
    #2 reset = 1'b1; #1;
    tests_run++; if (pc !== 32'h80000000 || epc !== 32'h0 || pending !== 4'b0000) begin tests_failed++; $display("FAIL async_reset: pc=%h epc=%h pending=%b want 80000000/0/0000", pc, epc, pending); end
    step();
    tests_run++; if (pc !== 32'h80000000) begin tests_failed++; $display("FAIL reset_hold: pc=%h want 80000000", pc); end
    reset = 1'b0; pc_src = 3'd0; step();
    tests_run++; if (pc !== 32'h80000004 || pending !== 4'b0011) begin tests_failed++; $display("FAIL post_reset: pc=%h pending=%b want 80000004/0011", pc, pending); end
    $display("[TB] mid reset: pc=%h pending=%b", pc, pending);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; pc_src = 3'd0; br_taken = 1'b0; br_off = 32'h0;
    jidx = 26'h0; jr_tgt = 32'h0; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
    step(); step();
    test_reset();
    test_seq();
    test_branch_jump();
    test_jr();
    test_wrap();
    test_irq_priority();
    test_illop_vs_irq();
    test_stall();
    test_clear_collision();
    test_mask();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
